// File: rtl/aidc_lite_code_split.sv
// ---------------------------------------------------------------------------
// aidc_lite_code_split
//
// Read-side bit-stream extractor for the AIDC-Lite decompression path. It
// fetches one 512-bit compressed block as eight 64-bit words (MSB-first) from
// a block buffer, strips the 2-bit block prefix and presents a left-aligned
// peek window to the code decoder. The decoder consumes a variable number of
// bits on each handshake.
//
// Build option:
//   AIDC_LITE_SPLIT_PREFIX_CHECK_EN  defined   -> a stripped prefix that differs
//                                                from PREFIX marks the block failed
//                                    undefined -> prefix is stripped, never compared
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         pulse: begin extracting a new block (ignored outside IDLE)
//   rd_en_o         block-buffer read request
//   rd_addr_o[2:0]  word address, 0 = MSB-first word
//   rd_data_i[63:0] read data, valid the cycle after rd_en_o
//   valid_o         peek window valid
//   data_o          next unconsumed bits, MSB = oldest, zero beyond avail_o
//   avail_o[7:0]    unconsumed bits held in the window
//   ready_i         decoder accepts size_i bits this cycle
//   size_i[6:0]     bits consumed by this handshake
//   eop_i           this handshake carries the block's last code
//   done_o          block finished (level, held until next start)
//   fail_o          block error (meaningful while done_o = 1)
//
// state | meaning
// IDLE  | no block in flight, done_o held, waiting for start_i
// FILL  | first word requested, waiting for it to strip the prefix
// RUN   | window serving the decoder, remaining words fetched on demand
// ---------------------------------------------------------------------------
module aidc_lite_code_split #(
    parameter logic [1:0] PREFIX    = 2'b00,
    parameter int         DATA_SIZE = 66
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    output logic                 rd_en_o,
    output logic [2:0]           rd_addr_o,
    input  logic [63:0]          rd_data_i,
    output logic                 valid_o,
    output logic [DATA_SIZE-1:0] data_o,
    output logic [7:0]           avail_o,
    input  logic                 ready_i,
    input  logic [6:0]           size_i,
    input  logic                 eop_i,
    output logic                 done_o,
    output logic                 fail_o
);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

`ifdef AIDC_LITE_SPLIT_PREFIX_CHECK_EN
    localparam logic PFX_CHECK = 1'b1;
`else
    localparam logic PFX_CHECK = 1'b0;
`endif

    localparam logic [7:0] DATA_SIZE_C = 8'(DATA_SIZE);

    state_t        state_q, state_d;
    logic [191:0]  win_q, win_d, win_s;
    logic [7:0]    buf_q, buf_d, buf_s;
    logic [3:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          ret_q;
    logic [10:0]   tot_q, tot_d;
    logic [11:0]   tot_sum;
    logic          flag_q, flag_d;
    logic          done_d, fail_d, valid_d, rd_en_d;
    logic [2:0]    rd_addr_d;
    logic          hs, ret, issue;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        tot_d     = tot_q;
        flag_d    = flag_q;
        done_d    = done_o;
        fail_d    = fail_o;
        win_s     = win_q;
        buf_s     = buf_q;
        tot_sum   = '0;
        issue     = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_o;
        valid_d   = 1'b0;

        hs  = (state_q == RUN) && valid_o && ready_i;
        // A return that belongs to an abandoned block is never appended.
        ret = ret_q && (state_q != IDLE);

        // Consume first; a word returning this cycle lands at the reduced count.
        if (hs) begin
            win_s   = win_q << size_i;
            buf_s   = ({1'b0, size_i} > buf_q) ? 8'd0 : buf_q - {1'b0, size_i};
            if (({1'b0, size_i} > buf_q) || (size_i == 7'd0))
                flag_d = 1'b1;
            tot_sum = {1'b0, tot_q} + {5'b0, size_i};
            tot_d   = tot_sum[11] ? 11'h7ff : tot_sum[10:0];
        end
        win_d = win_s;
        buf_d = buf_s;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FILL;
                    win_d   = '0;
                    buf_d   = '0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    tot_d   = '0;
                    flag_d  = 1'b0;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            FILL: begin
                if (ret) begin
                    if (PFX_CHECK && (rd_data_i[63:62] != PREFIX))
                        flag_d = 1'b1;
                    win_d   = {rd_data_i[61:0], 130'b0};
                    buf_d   = 8'd62;
                    tot_d   = 11'd2;
                    pend_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ret) begin
                    win_d  = win_s | ({rd_data_i, 128'b0} >> buf_s);
                    buf_d  = buf_s + 8'd64;
                    pend_d = 1'b0;
                end
                if (hs && eop_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    fail_d  = flag_d | (tot_d > 11'd512);
                    pend_d  = 1'b0;
                end else if ((cnt_q == 4'd8) && !pend_q && (buf_q == 8'd0)) begin
                    // Block ran dry without an end-of-block code.
                    state_d = IDLE;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Fetch decision on next-cycle values so rd_en_o can be a plain flop.
        // buf < 128 with a single outstanding read bounds the window at 191 bits.
        issue = (state_d != IDLE) && (cnt_d < 4'd8) && !pend_d && (buf_d < 8'd128);
        if (issue) begin
            rd_en_d   = 1'b1;
            rd_addr_d = cnt_d[2:0];
            cnt_d     = cnt_d + 4'd1;
            pend_d    = 1'b1;
        end

        valid_d = (state_d == RUN) &&
                  ((buf_d >= DATA_SIZE_C) ||
                   ((cnt_d == 4'd8) && !pend_d && (buf_d != 8'd0)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_q     <= '0;
            buf_q     <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            ret_q     <= 1'b0;
            tot_q     <= '0;
            flag_q    <= 1'b0;
            done_o    <= 1'b1;
            fail_o    <= 1'b0;
            valid_o   <= 1'b0;
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            ret_q     <= rd_en_o && (state_d != IDLE);
            tot_q     <= tot_d;
            flag_q    <= flag_d;
            done_o    <= done_d;
            fail_o    <= fail_d;
            valid_o   <= valid_d;
            rd_en_o   <= rd_en_d;
            rd_addr_o <= rd_addr_d;
        end
    end

    assign data_o  = win_q[191 -: DATA_SIZE];
    assign avail_o = buf_q;

endmodule

// File: tb/tb_aidc_lite_code_split.sv
// ---------------------------------------------------------------------------
// Self-checking bench for aidc_lite_code_split. A table of block scenarios
// (prefix, consume sizes, end point, ready behaviour, expected fail) is run
// against a block-buffer model; the reference bitstream and the expected read
// addresses are queued at start and popped as the DUT reads and is consumed.
// Hand-written sequences cover reset values and reset during a pending read.
// ---------------------------------------------------------------------------
module tb_aidc_lite_code_split;

    localparam int DS = 66;

`ifdef AIDC_LITE_SPLIT_PREFIX_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic          rd_en_o;
    logic [2:0]    rd_addr_o;
    logic [63:0]   rd_data_i;
    logic          valid_o;
    logic [DS-1:0] data_o;
    logic [7:0]    avail_o;
    logic          ready_i;
    logic [6:0]    size_i;
    logic          eop_i;
    logic          done_o;
    logic          fail_o;

    aidc_lite_code_split #(.PREFIX(2'b00), .DATA_SIZE(DS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .rd_en_o  (rd_en_o),
        .rd_addr_o(rd_addr_o),
        .rd_data_i(rd_data_i),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .avail_o  (avail_o),
        .ready_i  (ready_i),
        .size_i   (size_i),
        .eop_i    (eop_i),
        .done_o   (done_o),
        .fail_o   (fail_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] pfx;
        int         sz_first;
        int         sz;
        int         eop_tot;    // 0 = never send eop (underrun)
        bit         rnd;
        bit         zero;       // first handshake uses size 0
        bit         exp_fail;
    } vec_t;

    vec_t        vecs [8];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] mem [8];
    logic        ref_q [$];
    logic [2:0]  exp_addr [$];
    logic        pend_v = 1'b0;
    logic [2:0]  pend_a = '0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic pop_ref();
        if (ref_q.size() == 0) return 1'b0;
        return ref_q.pop_front();
    endfunction

    // One clock: block-buffer model, read-address scoreboard, window invariants.
    task automatic tick();
        logic [DS-1:0] tail;
        @(negedge clk);
        rd_data_i = pend_v ? mem[pend_a] : {$urandom, $urandom};
        pend_v    = rd_en_o;
        pend_a    = rd_addr_o;
        if (rd_en_o) begin
            if (exp_addr.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_addr: got unexpected read of %0d, required none", rd_addr_o);
            end else begin
                chk("rd_addr", rd_addr_o, exp_addr.pop_front());
            end
        end
        n_cmp++;
        if (avail_o > 8'd192) begin
            n_bad++;
            $display("FAIL avail_max: got %0d required <= 192", avail_o);
        end
        tail = data_o << avail_o;
        chk("tail_zero", tail, '0);
    endtask

    task automatic load_block(input logic [1:0] pfx);
        logic [63:0] w;
        ref_q.delete();
        exp_addr.delete();
        for (int k = 0; k < 8; k++) begin
            w = {$urandom, $urandom};
            if (k == 0) w[63:62] = pfx;
            mem[k] = w;
            for (int b = 63; b >= 0; b--)
                if (k > 0 || b < 62) ref_q.push_back(w[b]);
            exp_addr.push_back(3'(k));
        end
    endtask

    task automatic run_block(input vec_t v);
        int            tot, s, bud;
        bit            first, zdone, fin;
        logic [DS-1:0] exp_w, msk;
        load_block(v.pfx);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("rd_en_lat", rd_en_o, 1'b1);
        chk("done_clr", done_o, 1'b0);
        tot = 2; first = 1'b1; zdone = !v.zero; fin = 1'b0; bud = 0;
        while (!fin && bud < 3000) begin
            bud++;
            ready_i = 1'b0; eop_i = 1'b0; size_i = '0;
            if (valid_o) begin
                if (first) begin
                    chk("first_avail", avail_o, 8'd126);
                    first = 1'b0;
                end
                if (!v.rnd || ($urandom_range(1) == 1)) begin
                    if (!zdone) begin
                        ready_i = 1'b1;
                        zdone   = 1'b1;
                    end else begin
                        s = (tot == 2) ? v.sz_first : v.sz;
                        if (v.eop_tot > 0 && tot + s >= v.eop_tot) begin
                            s = v.eop_tot - tot; eop_i = 1'b1; fin = 1'b1;
                        end else if (v.eop_tot == 0 && tot + s >= 512) begin
                            s = 512 - tot; fin = 1'b1;
                        end
                        exp_w = '0; msk = '0;
                        for (int i = 0; i < s; i++) begin
                            exp_w[DS-1-i] = pop_ref();
                            msk[DS-1-i]   = 1'b1;
                        end
                        chk("chunk", data_o & msk, exp_w);
                        ready_i = 1'b1;
                        size_i  = 7'(s);
                        tot    += s;
                    end
                end
            end
            tick();
        end
        ready_i = 1'b0; eop_i = 1'b0; size_i = '0;
        if (!fin) begin
            n_cmp++; n_bad++;
            $display("FAIL block_timeout: got tot %0d required block completion", tot);
        end
        if (v.eop_tot == 0) begin
            bud = 0;
            while (!done_o && bud < 8) begin tick(); bud++; end
        end
        chk("done_end", done_o, 1'b1);
        chk("valid_end", valid_o, 1'b0);
        chk("fail_end", fail_o, v.exp_fail);
        if (v.eop_tot == 0 || v.eop_tot >= 512)
            chk("all_reads", exp_addr.size(), 0);
        tick();
        chk("done_hold", done_o, 1'b1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_en"},   rd_en_o,   1'b0);
        chk({tag, "_rd_addr"}, rd_addr_o, 3'd0);
        chk({tag, "_valid"},   valid_o,   1'b0);
        chk({tag, "_data"},    data_o,    '0);
        chk({tag, "_avail"},   avail_o,   8'd0);
        chk({tag, "_done"},    done_o,    1'b1);
        chk({tag, "_fail"},    fail_o,    1'b0);
    endtask

    initial begin
        int bud;
        vecs[0] = '{2'b00,  6, 34, 512, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'b11, 64, 64, 512, 1'b0, 1'b0, CHK};
        vecs[2] = '{2'b00, 38, 38,  40, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{2'b00, 66, 66, 520, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{2'b00,  1,  1, 512, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{2'b01, 20, 20, 512, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{2'b00, 50, 50,   0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{2'b10, 66, 66, 512, 1'b1, 1'b0, CHK};

        rst_n = 1'b0; start_i = 1'b0; ready_i = 1'b0; size_i = '0; eop_i = 1'b0;
        rd_data_i = '0;
        tick(); tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 8; t++) run_block(vecs[t]);

        // Reset while a word read is outstanding in RUN.
        load_block(2'b00);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        bud = 0;
        while (!(valid_o && rd_en_o) && bud < 50) begin tick(); bud++; end
        chk("rst_setup_pend", valid_o && rd_en_o, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        #2 rst_n = 1'b1;
        exp_addr.delete();
        tick(); tick(); tick();
        chk("post_rst_avail", avail_o, 8'd0);
        chk("post_rst_valid", valid_o, 1'b0);
        chk("post_rst_done", done_o, 1'b1);
        chk("post_rst_rd_en", rd_en_o, 1'b0);

        // A block after the reset starts again from address 0.
        run_block(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
